// File: rtl/gat_sched_pkg.sv
// Shared types and constants for the GAT layer scheduler.
// Holds the phase state encoding, load_done bit positions and the base-address stride helpers.
package gat_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BRAM,
        ST_LOAD_PARAM,
        ST_SPMM,
        ST_HANDOFF,
        ST_DRAIN,
        ST_FINISH,
        ST_ERR
    } sched_state_t;

    localparam int LD_WIDTH       = 5;
    localparam int LD_A           = 0;
    localparam int LD_WEIGHT      = 1;
    localparam int LD_H_NODE_INFO = 2;
    localparam int LD_H_VALUE     = 3;
    localparam int LD_H_COL_IDX   = 4;

    function automatic int w_stride(input int rows, input int cols);
        return rows * cols;
    endfunction

    // The attention vector holds two halves (self and neighbour) per head.
    function automatic int a_stride(input int cols);
        return 2 * cols;
    endfunction

endpackage

// File: rtl/gat_sched_bank_tracker.sv
// Owns the ping-pong WH bank pointer and the DMVM outstanding flag.
// A launch in the same cycle as a DMVM completion keeps the busy flag set.
module gat_sched_bank_tracker (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic launch,
    input  logic dmvm_done_i,
    output logic dmvm_busy,
    output logic wr_bank,
    output logic dmvm_start_o,
    output logic dmvm_bank_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmvm_busy    <= 1'b0;
            wr_bank      <= 1'b0;
            dmvm_start_o <= 1'b0;
            dmvm_bank_o  <= 1'b0;
        end else if (clr) begin
            dmvm_busy    <= 1'b0;
            wr_bank      <= 1'b0;
            dmvm_start_o <= 1'b0;
            dmvm_bank_o  <= 1'b0;
        end else begin
            dmvm_start_o <= launch;
            if (launch) begin
                dmvm_busy   <= 1'b1;
                dmvm_bank_o <= wr_bank;
                wr_bank     <= ~wr_bank;
            end else if (dmvm_done_i) begin
                dmvm_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gat_layer_scheduler.sv
// Phase sequencer for multi-head, multi-layer GAT inference: loader kick, SPMM, DMVM handoff
// with SPMM of head h+1 overlapping DMVM of head h, plus a watchdog and abort path.
module gat_layer_scheduler
    import gat_sched_pkg::*;
#(
    parameter int NUM_HEADS       = 8,
    parameter int NUM_LAYERS      = 2,
    parameter int W_NUM_OF_ROWS   = 1433,
    parameter int W_NUM_OF_COLS   = 16,
    parameter int BRAM_ADDR_WIDTH = 32,
    parameter int TIMEOUT_WIDTH   = 20
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic                                  abort_i,
    input  logic                                  err_clr_i,
    input  logic [LD_WIDTH-1:0]                   load_done_i,
    output logic                                  w_start_o,
    output logic                                  a_start_o,
    input  logic                                  w_ready_i,
    input  logic                                  a_ready_i,
    output logic [BRAM_ADDR_WIDTH-1:0]            w_base_addr_o,
    output logic [BRAM_ADDR_WIDTH-1:0]            a_base_addr_o,
    output logic                                  spmm_start_o,
    input  logic                                  spmm_done_i,
    output logic                                  wh_wr_bank_o,
    output logic                                  dmvm_start_o,
    input  logic                                  dmvm_done_i,
    output logic                                  dmvm_bank_o,
    output logic [$clog2(NUM_HEADS+1)-1:0]        head_idx_o,
    output logic [$clog2(NUM_LAYERS+1)-1:0]       layer_idx_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  error_o
);

    localparam int HW = $clog2(NUM_HEADS + 1);
    localparam int LW = $clog2(NUM_LAYERS + 1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] W_STRIDE =
        BRAM_ADDR_WIDTH'(w_stride(W_NUM_OF_ROWS, W_NUM_OF_COLS));
    localparam logic [BRAM_ADDR_WIDTH-1:0] A_STRIDE = BRAM_ADDR_WIDTH'(a_stride(W_NUM_OF_COLS));
    localparam logic [HW-1:0] LAST_HEAD  = HW'(NUM_HEADS - 1);
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

    sched_state_t                 state, state_n;
    logic                         w_start_n, a_start_n, spmm_start_n, done_n, err_n;
    logic                         w_got, a_got, w_got_n, a_got_n;
    logic [HW-1:0]                head_n;
    logic [LW-1:0]                layer_n;
    logic [BRAM_ADDR_WIDTH-1:0]   w_base_n, a_base_n;
    logic [TIMEOUT_WIDTH-1:0]     wdog, wdog_n;
    logic                         enter_load, launch, wait_st, wdog_clr, bram_ready;
    logic                         dmvm_busy, trk_clr;

    assign bram_ready = load_done_i[LD_H_COL_IDX] & load_done_i[LD_H_VALUE] &
                        load_done_i[LD_H_NODE_INFO] & load_done_i[LD_WEIGHT] & load_done_i[LD_A];
    assign wait_st    = (state == ST_WAIT_BRAM) || (state == ST_LOAD_PARAM) || (state == ST_SPMM) ||
                        (state == ST_HANDOFF) || (state == ST_DRAIN);
    assign wdog_clr   = w_start_o | a_start_o | spmm_start_o | dmvm_start_o |
                        w_ready_i | a_ready_i | spmm_done_i | dmvm_done_i;
    assign busy_o     = (state != ST_IDLE) && (state != ST_ERR);
    assign trk_clr    = abort_i || ((state == ST_ERR) && err_clr_i);

    always_comb begin
        state_n      = state;
        w_start_n    = 1'b0;
        a_start_n    = 1'b0;
        spmm_start_n = 1'b0;
        done_n       = 1'b0;
        enter_load   = 1'b0;
        launch       = 1'b0;
        w_got_n      = w_got;
        a_got_n      = a_got;
        head_n       = head_idx_o;
        layer_n      = layer_idx_o;
        w_base_n     = w_base_addr_o;
        a_base_n     = a_base_addr_o;
        wdog_n       = '0;
        err_n        = error_o;

        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_n = ST_WAIT_BRAM;
                    head_n  = '0;
                    layer_n = '0;
                end
            end
            ST_WAIT_BRAM: begin
                if (bram_ready) begin
                    state_n    = ST_LOAD_PARAM;
                    enter_load = 1'b1;
                end
            end
            ST_LOAD_PARAM: begin
                if (w_ready_i) w_got_n = 1'b1;
                if (a_ready_i) a_got_n = 1'b1;
                if (w_got_n && a_got_n) begin
                    state_n      = ST_SPMM;
                    spmm_start_n = 1'b1;
                end
            end
            ST_SPMM: begin
                if (spmm_done_i) state_n = ST_HANDOFF;
            end
            // A DMVM completing this very cycle frees the bank, so launch without a bubble.
            ST_HANDOFF: begin
                if (!dmvm_busy || dmvm_done_i) begin
                    launch = 1'b1;
                    head_n = head_idx_o + HW'(1);
                    if (head_idx_o == LAST_HEAD) begin
                        state_n = ST_DRAIN;
                    end else begin
                        state_n    = ST_LOAD_PARAM;
                        enter_load = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!dmvm_busy) begin
                    if (layer_idx_o == LAST_LAYER) begin
                        state_n = ST_FINISH;
                        done_n  = 1'b1;
                    end else begin
                        state_n    = ST_LOAD_PARAM;
                        enter_load = 1'b1;
                        layer_n    = layer_idx_o + LW'(1);
                        head_n     = '0;
                    end
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            ST_ERR: begin
                if (err_clr_i) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (wait_st && !wdog_clr && (state_n == state) && (wdog == {TIMEOUT_WIDTH{1'b1}})) begin
            state_n = ST_ERR;
        end
        if (wait_st && !wdog_clr && (state_n == state)) wdog_n = wdog + TIMEOUT_WIDTH'(1);

        if (enter_load) begin
            w_start_n = 1'b1;
            a_start_n = 1'b1;
            w_got_n   = 1'b0;
            a_got_n   = 1'b0;
            if (head_n == '0) begin
                w_base_n = '0;
                a_base_n = '0;
            end else begin
                w_base_n = w_base_addr_o + W_STRIDE;
                a_base_n = a_base_addr_o + A_STRIDE;
            end
        end

        if (abort_i) begin
            state_n      = ST_IDLE;
            w_start_n    = 1'b0;
            a_start_n    = 1'b0;
            spmm_start_n = 1'b0;
            done_n       = 1'b0;
            launch       = 1'b0;
            w_got_n      = 1'b0;
            a_got_n      = 1'b0;
            head_n       = '0;
            layer_n      = '0;
            w_base_n     = '0;
            a_base_n     = '0;
            wdog_n       = '0;
        end

        if ((state_n == ST_ERR) && (state != ST_ERR)) err_n = 1'b1;
        else if (err_clr_i)                           err_n = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            w_start_o     <= 1'b0;
            a_start_o     <= 1'b0;
            spmm_start_o  <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            w_got         <= 1'b0;
            a_got         <= 1'b0;
            head_idx_o    <= '0;
            layer_idx_o   <= '0;
            w_base_addr_o <= '0;
            a_base_addr_o <= '0;
            wdog          <= '0;
        end else begin
            state         <= state_n;
            w_start_o     <= w_start_n;
            a_start_o     <= a_start_n;
            spmm_start_o  <= spmm_start_n;
            done_o        <= done_n;
            error_o       <= err_n;
            w_got         <= w_got_n;
            a_got         <= a_got_n;
            head_idx_o    <= head_n;
            layer_idx_o   <= layer_n;
            w_base_addr_o <= w_base_n;
            a_base_addr_o <= a_base_n;
            wdog          <= wdog_n;
        end
    end

    gat_sched_bank_tracker u_bank_tracker (
        .clk          (clk),
        .rst          (rst),
        .clr          (trk_clr),
        .launch       (launch),
        .dmvm_done_i  (dmvm_done_i),
        .dmvm_busy    (dmvm_busy),
        .wr_bank      (wh_wr_bank_o),
        .dmvm_start_o (dmvm_start_o),
        .dmvm_bank_o  (dmvm_bank_o)
    );

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Scoreboard bench for gat_layer_scheduler: behavioural engine responders, an expected-event
// model built from head/layer arithmetic, and a monitor that pops and compares on every pulse.
module tb_gat_layer_scheduler;

    localparam int H    = 3;
    localparam int L    = 2;
    localparam int ROWS = 5;
    localparam int COLS = 4;
    localparam int AW   = 16;
    localparam int TW   = 6;
    localparam int HW   = $clog2(H + 1);
    localparam int LW   = $clog2(L + 1);

    logic          clk = 1'b0, rst = 1'b1;
    logic          start_i = 1'b0, abort_i = 1'b0, err_clr_i = 1'b0;
    logic [4:0]    load_done_i = 5'h00;
    logic          w_start_o, a_start_o, w_ready_i, a_ready_i;
    logic [AW-1:0] w_base_addr_o, a_base_addr_o;
    logic          spmm_start_o, spmm_done_i, wh_wr_bank_o;
    logic          dmvm_start_o, dmvm_done_i, dmvm_bank_o;
    logic [HW-1:0] head_idx_o;
    logic [LW-1:0] layer_idx_o;
    logic          busy_o, done_o, error_o;

    always #5 clk = ~clk;

    gat_layer_scheduler #(
        .NUM_HEADS(H), .NUM_LAYERS(L), .W_NUM_OF_ROWS(ROWS), .W_NUM_OF_COLS(COLS),
        .BRAM_ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .err_clr_i(err_clr_i),
        .load_done_i(load_done_i), .w_start_o(w_start_o), .a_start_o(a_start_o),
        .w_ready_i(w_ready_i), .a_ready_i(a_ready_i), .w_base_addr_o(w_base_addr_o),
        .a_base_addr_o(a_base_addr_o), .spmm_start_o(spmm_start_o), .spmm_done_i(spmm_done_i),
        .wh_wr_bank_o(wh_wr_bank_o), .dmvm_start_o(dmvm_start_o), .dmvm_done_i(dmvm_done_i),
        .dmvm_bank_o(dmvm_bank_o), .head_idx_o(head_idx_o), .layer_idx_o(layer_idx_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    typedef struct { int w_base; int a_base; int head; int layer; } load_exp_t;
    typedef struct { int bank; int head; int layer; } spmm_exp_t;

    load_exp_t q_load[$];
    spmm_exp_t q_spmm[$];
    int        q_dmvm[$];
    int        q_done[$];

    int errors = 0, checks = 0;
    int bank_model = 0;
    int cyc = 0, wstart_cnt = 0, spmm_start_cnt = 0, done_cnt = 0, dmvm_done_cnt = 0;
    bit overlap_seen = 0, coincide_seen = 0;
    int lat_l_lo = 1, lat_l_hi = 1, lat_s_lo = 10, lat_s_hi = 10, lat_d_lo = 30, lat_d_hi = 30;
    bit hold_w = 0, align = 0, spurious = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Engine responders: loaders, SPMM and DMVM, driven away from the active edge.
    initial begin
        int w_cnt = 0, a_cnt = 0, s_cnt = 0, d_cnt = 0;
        w_ready_i = 0; a_ready_i = 0; spmm_done_i = 0; dmvm_done_i = 0;
        forever begin
            @(negedge clk);
            w_ready_i = 0; a_ready_i = 0; spmm_done_i = 0; dmvm_done_i = 0;
            if (dmvm_start_o) check("dmvm_idle_at_launch", d_cnt, 0);
            if (spurious) begin
                spmm_done_i = 1; dmvm_done_i = 1; spurious = 0;
            end
            if (w_cnt > 0) begin w_cnt--; if (w_cnt == 0 && !hold_w) w_ready_i = 1; end
            if (a_cnt > 0) begin a_cnt--; if (a_cnt == 0) a_ready_i = 1; end
            if (d_cnt > 0) begin
                d_cnt--;
                if (d_cnt == 0) begin dmvm_done_i = 1; dmvm_done_cnt++; end
            end
            if (s_cnt > 0) begin
                s_cnt--;
                if (s_cnt == 0) begin spmm_done_i = 1; if (dmvm_done_i) coincide_seen = 1; end
            end
            if (w_start_o) w_cnt = $urandom_range(lat_l_hi, lat_l_lo);
            if (a_start_o) a_cnt = $urandom_range(lat_l_hi, lat_l_lo);
            if (spmm_start_o) begin
                if (d_cnt != 0) overlap_seen = 1;
                s_cnt = (align && d_cnt > 0) ? d_cnt : $urandom_range(lat_s_hi, lat_s_lo);
            end
            if (dmvm_start_o) d_cnt = $urandom_range(lat_d_hi, lat_d_lo);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    initial begin
        load_exp_t le;
        spmm_exp_t se;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (w_start_o) begin
                wstart_cnt++;
                check("a_start_with_w_start", longint'(a_start_o), 1);
                if (q_load.size() == 0) check("unexpected_w_start", 1, 0);
                else begin
                    le = q_load.pop_front();
                    check("w_base_addr", longint'(w_base_addr_o), le.w_base);
                    check("a_base_addr", longint'(a_base_addr_o), le.a_base);
                    check("load_head_idx", longint'(head_idx_o), le.head);
                    check("load_layer_idx", longint'(layer_idx_o), le.layer);
                end
            end
            if (spmm_start_o) begin
                spmm_start_cnt++;
                if (q_spmm.size() == 0) check("unexpected_spmm_start", 1, 0);
                else begin
                    se = q_spmm.pop_front();
                    check("spmm_wr_bank", longint'(wh_wr_bank_o), se.bank);
                    check("spmm_head_idx", longint'(head_idx_o), se.head);
                    check("spmm_layer_idx", longint'(layer_idx_o), se.layer);
                    check("layer_barrier", longint'(dmvm_done_cnt >= se.layer * H), 1);
                end
            end
            if (dmvm_start_o) begin
                if (q_dmvm.size() == 0) check("unexpected_dmvm_start", 1, 0);
                else check("dmvm_bank", longint'(dmvm_bank_o), q_dmvm.pop_front());
            end
            if (done_o) begin
                done_cnt++;
                if (q_done.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    void'(q_done.pop_front());
                    check("all_dmvm_done_at_finish", dmvm_done_cnt, H * L);
                end
            end
        end
    end

    task automatic push_run();
        for (int l = 0; l < L; l++) begin
            for (int h = 0; h < H; h++) begin
                q_load.push_back('{h * ROWS * COLS, h * 2 * COLS, h, l});
                q_spmm.push_back('{bank_model, h, l});
                q_dmvm.push_back(bank_model);
                bank_model ^= 1;
            end
        end
        q_done.push_back(1);
    endtask

    task automatic do_run(input string name, input int bram_delay, input bit restart_mid);
        int d0, n, w0;
        d0 = done_cnt;
        dmvm_done_cnt = 0;
        push_run();
        load_done_i = (bram_delay > 0) ? 5'b01111 : 5'b11111;
        @(negedge clk); start_i = 1;
        @(negedge clk); start_i = 0;
        if (bram_delay > 0) begin
            w0 = wstart_cnt;
            repeat (bram_delay) @(negedge clk);
            check({name, "_wait_bram_holds"}, wstart_cnt - w0, 0);
            check({name, "_busy_in_wait"}, longint'(busy_o), 1);
            load_done_i = 5'b11111;
        end
        if (restart_mid) begin
            repeat (20) @(negedge clk);
            start_i = 1; @(negedge clk); start_i = 0;
        end
        n = 0;
        while (done_cnt == d0 && n < 5000) begin @(negedge clk); n++; end
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        @(negedge clk);
        check({name, "_idle_busy"}, longint'(busy_o), 0);
        check({name, "_idle_error"}, longint'(error_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, t0, dt, s0;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy_o), 0);
        check("rst_done", longint'(done_o), 0);
        check("rst_error", longint'(error_o), 0);
        check("rst_starts", longint'({w_start_o, a_start_o, spmm_start_o, dmvm_start_o}), 0);
        check("rst_bases", longint'(w_base_addr_o) + longint'(a_base_addr_o), 0);
        check("rst_idx_banks", longint'({head_idx_o, layer_idx_o, wh_wr_bank_o, dmvm_bank_o}), 0);
        rst = 0;
        repeat (2) @(negedge clk);

        overlap_seen = 0;
        do_run("run_basic", 6, 0);
        check("spmm_overlaps_dmvm", longint'(overlap_seen), 1);

        lat_s_lo = 5; lat_s_hi = 5; lat_d_lo = 50; lat_d_hi = 50;
        do_run("run_stall", 0, 0);

        align = 1; lat_d_lo = 30; lat_d_hi = 30; coincide_seen = 0;
        do_run("run_coincide", 0, 0);
        check("done_coincidence_seen", longint'(coincide_seen), 1);
        align = 0;

        for (int r = 0; r < 4; r++) begin
            lat_l_lo = 1; lat_l_hi = $urandom_range(8, 1);
            lat_s_lo = 1; lat_s_hi = $urandom_range(40, 1);
            lat_d_lo = 1; lat_d_hi = $urandom_range(45, 1);
            spurious = 1;
            repeat (3) @(negedge clk);
            do_run("run_random", 0, (r == 1));
        end

        // Abort during SPMM of head 0, then a clean run.
        lat_l_lo = 1; lat_l_hi = 1; lat_s_lo = 30; lat_s_hi = 30; lat_d_lo = 20; lat_d_hi = 20;
        q_load.push_back('{0, 0, 0, 0});
        q_spmm.push_back('{bank_model, 0, 0});
        s0 = spmm_start_cnt;
        @(negedge clk); start_i = 1; @(negedge clk); start_i = 0;
        n = 0;
        while (spmm_start_cnt == s0 && n < 200) begin @(negedge clk); n++; end
        check("abort_spmm_reached", spmm_start_cnt - s0, 1);
        repeat (3) @(negedge clk);
        abort_i = 1; @(negedge clk); abort_i = 0;
        check("abort_busy", longint'(busy_o), 0);
        check("abort_outputs", longint'({w_start_o, spmm_start_o, dmvm_start_o, done_o, wh_wr_bank_o}), 0);
        check("abort_idx_base", longint'(head_idx_o) + longint'(w_base_addr_o), 0);
        bank_model = 0;
        repeat (60) @(negedge clk);
        start_i = 1; abort_i = 1; @(negedge clk); start_i = 0; abort_i = 0;
        repeat (3) @(negedge clk);
        check("abort_beats_start", longint'(busy_o), 0);
        lat_s_lo = 1; lat_s_hi = 20; lat_d_lo = 1; lat_d_hi = 30;
        do_run("run_after_abort", 0, 0);

        // Watchdog: W loader never answers.
        hold_w = 1;
        q_load.push_back('{0, 0, 0, 0});
        s0 = wstart_cnt;
        @(negedge clk); start_i = 1; @(negedge clk); start_i = 0;
        n = 0;
        while (wstart_cnt == s0 && n < 100) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        while (!error_o && n < 300) begin @(negedge clk); n++; end
        dt = cyc - t0;
        check("wdog_error_set", longint'(error_o), 1);
        check("wdog_latency_in_range", longint'(dt >= 63 && dt <= 68), 1);
        check("err_busy_low", longint'(busy_o), 0);
        repeat (10) @(negedge clk);
        check("err_sticky", longint'(error_o), 1);
        check("err_starts_low", longint'({w_start_o, a_start_o, spmm_start_o, dmvm_start_o}), 0);
        hold_w = 0;
        err_clr_i = 1; @(negedge clk); err_clr_i = 0;
        @(negedge clk);
        check("err_clr_error", longint'(error_o), 0);
        check("err_clr_busy", longint'(busy_o), 0);
        do_run("run_after_err", 0, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", q_load.size() + q_spmm.size() + q_dmvm.size() + q_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
